debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in the input synchronizer chain; legal values 2..4.
REQ-002 Parameter HOLD, default 8: number of consecutive cycles the synchronized input must hold before the output changes; legal values 2..2**CNT_W.
REQ-003 Parameter CNT_W, default 4: width of the hold counter in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 nrst  input  1  reset; asynchronous, active-low.
REQ-006 d  input  1  raw asynchronous level, e.g. a switch or another clock domain.
REQ-007 o  output  1  debounced, synchronized level.
REQ-008 rise  output  1  one-cycle pulse on the cycle o goes 0->1.
REQ-009 fall  output  1  one-cycle pulse on the cycle o goes 1->0.
REQ-010 busy  output  1  high while the FSM is in a CHK state.
REQ-011 events  output  8  count of o transitions; present only with DEBOUNCE_EVENT_COUNT_EN.

Function
REQ-012 d passes through a SYNC_STAGES-deep flop chain; the last stage is signal s.
REQ-013 The FSM has four states: IDLE_LO, CHK_HI, IDLE_HI and CHK_LO; o is 1 only in IDLE_HI and CHK_LO.
REQ-014 IDLE_LO: if s=1, go to CHK_HI and set cnt=1; otherwise stay in IDLE_LO.
REQ-015 CHK_HI: if s=0, go to IDLE_LO and set cnt=0 (glitch rejected, no pulse).
REQ-016 CHK_HI: if s=1 and cnt==HOLD-1, go to IDLE_HI, set cnt=0, and assert rise for that one cycle.
REQ-017 CHK_HI: if s=1 and cnt!=HOLD-1, increment cnt.
REQ-018 IDLE_HI and CHK_LO mirror REQ-014..017 with s inverted, and fall is asserted in place of rise.
REQ-019 Latency: with d stable from before edge 1, o changes after edge SYNC_STAGES+HOLD, and rise/fall is high for exactly that cycle.
REQ-020 rise and fall are registered outputs, are never high simultaneously, and cannot repeat on consecutive cycles.
REQ-021 The counter never wraps; cnt is always in the range 0..HOLD-1.
REQ-022 A pulse on d shorter than HOLD cycles, as seen at s, produces no change on o, rise or fall.

Reset
REQ-023 nrst low clears immediately, independent of clk: sync chain=0, state=IDLE_LO, cnt=0, o=0, rise=0, fall=0, busy=0, events=0.
REQ-024 Reset asserted mid-CHK aborts the check with no pulse.
REQ-025 If d=1 at reset release, the block debounces normally and produces one rise pulse per REQ-019.

Configuration
REQ-026 Macro DEBOUNCE_EVENT_COUNT_EN: when defined, port events exists and increments by 1 on each rise or fall cycle, wrapping 255->0.
REQ-027 Without DEBOUNCE_EVENT_COUNT_EN, the events port and its register are absent, and all other behaviour is identical.

Structure
REQ-028 Shared package debounce_pkg holds the state enum (IDLE_LO, CHK_HI, IDLE_HI, CHK_LO) and the constant EVT_W=8.
REQ-029 The synchronizer is a sub-module sync_chain (parameter STAGES; ports clk, nrst, d, q), instantiated once.
REQ-030 Parameter legality (REQ-001, REQ-002) is checked at elaboration; an illegal value is a fatal error.

Verification (SYNC_STAGES=2, HOLD=4, CNT_W=4 unless noted)
REQ-031 Scenario 1: d 0->1 before edge 1 and held -> o=1 and rise=1 after edge 6; rise=0 after edge 7; busy high after edges 3..5.
REQ-032 Scenario 2: d=1 for 3 cycles, then 0 -> o stays 0; rise and fall never assert; busy returns low.
REQ-033 Scenario 3: o=1, then d bounces 1,0,1,0,0,0,0 one value per cycle -> a single fall pulse, 2+4 edges after the final 1->0.
REQ-034 Scenario 4: nrst pulsed low between edges while in CHK_HI with cnt=2 -> all outputs 0 at once with no clock edge; after release, d=1 yields rise 6 edges later.
REQ-035 Scenario 5 (DEBOUNCE_EVENT_COUNT_EN): 256 debounced transitions -> events reads 0 after the 256th and 1 after the 257th.
REQ-036 Scenario 6: HOLD=16, CNT_W=4 -> o changes after edge 18, and cnt never exceeds 15.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce/synchronizer block.
package debounce_pkg;

    localparam int EVT_W = 8;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; q is the last stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronize and debounce a raw level, with one-cycle rise/fall pulses.
// Optional transition counter on port events when DEBOUNCE_EVENT_COUNT_EN is defined.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD        = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             d,
    output logic             o,
    output logic             rise,
    output logic             fall,
    output logic             busy
`ifdef DEBOUNCE_EVENT_COUNT_EN
    ,
    output logic [EVT_W-1:0] events
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $fatal(1, "debounce_sync: SYNC_STAGES must be 2..4");
    end
    if (HOLD < 2 || HOLD > (1 << CNT_W)) begin : g_bad_hold
        $fatal(1, "debounce_sync: HOLD must be 2..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic       s;
    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (d),
        .q    (s)
    );

    // cnt counts consecutive samples of s that disagree with o; the HOLD-th flips o.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o    = (state_q == IDLE_HI) || (state_q == CHK_LO);
    assign busy = (state_q == CHK_HI) || (state_q == CHK_LO);
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_EVENT_COUNT_EN
    logic [EVT_W-1:0] events_q, events_d;

    always_comb begin
        events_d = events_q;
        if (rise_d || fall_d) begin
            events_d = events_q + EVT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            events_q <= '0;
        end else begin
            events_q <= events_d;
        end
    end

    assign events = events_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: vector table, hand-written corner sequences, random run against a run-length model.
module tb_debounce_sync;

    localparam int SYNC = 2;
    localparam int HOLD = 4;

    typedef struct {
        bit d;
        bit o;
        bit rise;
        bit fall;
        bit busy;
    } vec_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic d    = 1'b0;
    logic d16  = 1'b0;
    logic o, rise, fall, busy;
    logic o16, rise16, fall16, busy16;
`ifdef DEBOUNCE_EVENT_COUNT_EN
    logic [7:0] events, events16;
`endif

    always #5 clk = ~clk;

    debounce_sync #(.SYNC_STAGES(SYNC), .HOLD(HOLD), .CNT_W(4)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .d      (d),
        .o      (o),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
`ifdef DEBOUNCE_EVENT_COUNT_EN
        ,
        .events (events)
`endif
    );

    debounce_sync #(.SYNC_STAGES(2), .HOLD(16), .CNT_W(4)) dut16 (
        .clk    (clk),
        .nrst   (nrst),
        .d      (d16),
        .o      (o16),
        .rise   (rise16),
        .fall   (fall16),
        .busy   (busy16)
`ifdef DEBOUNCE_EVENT_COUNT_EN
        ,
        .events (events16)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: o flips once s has disagreed with o on HOLD consecutive edges.
    bit       mq[$];
    bit       m_o, m_rise, m_fall;
    int       m_run;
    bit [7:0] m_ev;

    function automatic void m_reset();
        mq = {};
        for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
        m_o = 0; m_rise = 0; m_fall = 0; m_run = 0; m_ev = 8'd0;
    endfunction

    function automatic void m_edge(bit din);
        bit s;
        s = mq.pop_front();
        mq.push_back(din);
        m_rise = 0;
        m_fall = 0;
        if (s != m_o) begin
            m_run++;
            if (m_run == HOLD) begin
                m_o   = s;
                m_run = 0;
                if (s) m_rise = 1; else m_fall = 1;
                m_ev = m_ev + 8'd1;
            end
        end else begin
            m_run = 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (nrst) m_edge(d);
        #1;
        chk("o", int'(o), int'(m_o));
        chk("rise", int'(rise), int'(m_rise));
        chk("fall", int'(fall), int'(m_fall));
        chk("busy", int'(busy), int'(m_run != 0));
        chk("rise_fall_excl", int'(rise & fall), 0);
`ifdef DEBOUNCE_EVENT_COUNT_EN
        chk("events", int'(events), int'(m_ev));
`endif
    endtask

    // Called at posedge+1: asserts reset between edges, checks, releases on the negedge.
    task automatic async_reset();
        #2 nrst = 1'b0;
        m_reset();
        #1;
        chk("rst_o", int'(o), 0);
        chk("rst_rise", int'(rise), 0);
        chk("rst_fall", int'(fall), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef DEBOUNCE_EVENT_COUNT_EN
        chk("rst_events", int'(events), 0);
`endif
        #1 nrst = 1'b1;
    endtask

    vec_t tbl[8];
    int   pulses;
    int   fall_idx;
    bit   bnc[13];

    initial begin
        // Scenario 1 expectations, one record per edge after d rises before edge 1.
        tbl[0] = '{1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 0, 0, 1};
        tbl[3] = '{1, 0, 0, 0, 1};
        tbl[4] = '{1, 0, 0, 0, 1};
        tbl[5] = '{1, 1, 1, 0, 0};
        tbl[6] = '{1, 1, 0, 0, 0};
        tbl[7] = '{1, 1, 0, 0, 0};
        bnc = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        m_reset();
        #3;
        chk("reset_o", int'(o), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_fall", int'(fall), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_o16", int'(o16), 0);
        #9 nrst = 1'b1;

        // Scenario 1: basic rise latency
        for (int i = 0; i < 8; i++) begin
            d = tbl[i].d;
            step();
            chk($sformatf("s1_o[%0d]", i), int'(o), int'(tbl[i].o));
            chk($sformatf("s1_rise[%0d]", i), int'(rise), int'(tbl[i].rise));
            chk($sformatf("s1_fall[%0d]", i), int'(fall), int'(tbl[i].fall));
            chk($sformatf("s1_busy[%0d]", i), int'(busy), int'(tbl[i].busy));
        end

        // Scenario 2: short high pulse rejected
        d = 1'b0;
        repeat (10) step();
        chk("s2_pre_o", int'(o), 0);
        pulses = 0;
        d = 1'b1;
        repeat (3) begin step(); pulses += int'(rise) + int'(fall); end
        d = 1'b0;
        repeat (8) begin step(); pulses += int'(rise) + int'(fall) + int'(o); end
        chk("s2_no_pulse", pulses, 0);
        chk("s2_busy_low", int'(busy), 0);

        // Scenario 3: bouncing release yields one fall, 2+4 edges after the last 1->0
        d = 1'b1;
        repeat (10) step();
        chk("s3_pre_o", int'(o), 1);
        pulses = 0;
        fall_idx = -1;
        for (int i = 0; i < 13; i++) begin
            d = bnc[i];
            step();
            pulses += int'(fall) + int'(rise);
            if (fall) fall_idx = i;
        end
        chk("s3_one_pulse", pulses, 1);
        chk("s3_fall_edge", fall_idx, 3 + 5);
        chk("s3_o", int'(o), 0);

        // Scenario 4: reset in CHK_HI with cnt=2, then d=1 from release
        d = 1'b1;
        repeat (4) step();
        chk("s4_busy_before", int'(busy), 1);
        chk("s4_run_before", m_run, 2);
        async_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("s4_rise_e%0d", i), int'(rise), int'(i == 6));
        end
        chk("s4_o", int'(o), 1);
        repeat (2) step();
        async_reset();
        d = 1'b0;
        repeat (3) step();

        // Scenario 6: HOLD=16 instance, latency 2+16
        d16 = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            step();
            if (i == 17) begin
                chk("s6_o_e17", int'(o16), 0);
                chk("s6_busy_e17", int'(busy16), 1);
            end
            if (i == 18) begin
                chk("s6_o_e18", int'(o16), 1);
                chk("s6_rise_e18", int'(rise16), 1);
            end
            if (i == 19) chk("s6_rise_e19", int'(rise16), 0);
        end

        // Random runs of varying length against the model, with occasional resets
        for (int n = 0; n < 400; n++) begin
            d = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 7)) step();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

`ifdef DEBOUNCE_EVENT_COUNT_EN
        // Scenario 5: event counter wraps after 256 transitions
        async_reset();
        d = 1'b0;
        for (int t = 1; t <= 257; t++) begin
            bit want;
            int guard;
            want  = (t % 2) == 1;
            d     = want;
            guard = 0;
            while (m_o != want && guard < 20) begin
                step();
                guard++;
            end
            chk($sformatf("s5_done_%0d", t), int'(m_o == want), 1);
            if (t == 256) chk("s5_events_256", int'(events), 0);
            if (t == 257) chk("s5_events_257", int'(events), 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
